// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin shared-interface arbiter.
// rr_pick works on a fixed 16-bit view so one function serves every N_REQ.
package arb_pkg;

   localparam int HOLD_MAX_DEF = 16;
   localparam int MAX_REQ      = 16;
   localparam int MAX_ID_W     = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic [MAX_ID_W-1:0] idx;
      logic                found;
   } pick_t;

   // First set bit at or after ptr, wrapping at n_req (not at a power of two).
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                     input logic [MAX_ID_W-1:0] ptr,
                                     input int                  n_req);
      pick_t res;
      int    idx;
      res = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (i < n_req) begin
            idx = int'(ptr) + i;
            if (idx >= n_req) idx = idx - n_req;
            if (!res.found && req[idx[MAX_ID_W-1:0]]) begin
               res.idx   = idx[MAX_ID_W-1:0];
               res.found = 1'b1;
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational rotate-priority encoder: picks the first requester at or
// after ptr, wrapping past N_REQ-1 back to 0.
module rr_picker
   import arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [ID_W-1:0]  ptr,
   output logic [ID_W-1:0]  sel,
   output logic             found
);

   logic [MAX_REQ-1:0]  req_ext;
   logic [MAX_ID_W-1:0] ptr_ext;
   logic [MAX_ID_W-1:0] sel_ext;
   pick_t               pick;

   assign req_ext          = MAX_REQ'(req);
   assign ptr_ext          = MAX_ID_W'(ptr);
   assign pick             = rr_pick(req_ext, ptr_ext, N_REQ);
   assign {sel_ext, found} = pick;
   assign sel              = ID_W'(sel_ext);

endmodule

// File: rtl/shared_if_arbiter.sv
// Round-robin owner arbiter for one shared interface: grant held until last,
// request drop or hold limit, with a one-cycle turnaround between owners.
module shared_if_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int HOLD_MAX = HOLD_MAX_DEF,
   parameter int ID_W     = $clog2(N_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req,
   input  logic                          last,
   output logic [N_REQ-1:0]              gnt,
   output logic [ID_W-1:0]               gnt_id,
   output logic                          gnt_vld,
   output logic                          turnaround,
   output logic                          timeout,
   output logic [$clog2(HOLD_MAX+1)-1:0] hold_cnt
);

   localparam int              HC_W     = $clog2(HOLD_MAX + 1);
   localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX);
   localparam logic [ID_W-1:0] LAST_ID  = ID_W'(N_REQ - 1);

   arb_state_e      state, state_nxt;
   logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0] sel;
   logic            found;

   logic [N_REQ-1:0] gnt_nxt;
   logic [ID_W-1:0]  gnt_id_nxt;
   logic             gnt_vld_nxt;
   logic             turnaround_nxt;
   logic             timeout_nxt;
   logic [HC_W-1:0]  hold_cnt_nxt;

   logic rel_done, rel_drop, rel_limit;

   // Single picker serves both IDLE and RELEASE: both arbitrate from rr_ptr.
   rr_picker #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_picker (
      .req   (req),
      .ptr   (rr_ptr),
      .sel   (sel),
      .found (found)
   );

   assign rel_done  = last;
   assign rel_drop  = ~req[gnt_id];
   assign rel_limit = (hold_cnt == HOLD_LIM);

   always_comb begin
      state_nxt      = state;
      rr_ptr_nxt     = rr_ptr;
      gnt_nxt        = gnt;
      gnt_id_nxt     = gnt_id;
      gnt_vld_nxt    = gnt_vld;
      turnaround_nxt = 1'b0;
      timeout_nxt    = 1'b0;
      hold_cnt_nxt   = hold_cnt;
      unique case (state)
         IDLE, RELEASE: begin
            gnt_nxt      = '0;
            gnt_vld_nxt  = 1'b0;
            hold_cnt_nxt = '0;
            state_nxt    = IDLE;
            if (found) begin
               state_nxt      = GRANT;
               gnt_nxt[sel]   = 1'b1;
               gnt_id_nxt     = sel;
               gnt_vld_nxt    = 1'b1;
               hold_cnt_nxt   = HC_W'(1);
            end
         end
         GRANT: begin
            if (rel_done || rel_drop || rel_limit) begin
               state_nxt      = RELEASE;
               gnt_nxt        = '0;
               gnt_vld_nxt    = 1'b0;
               hold_cnt_nxt   = '0;
               turnaround_nxt = 1'b1;
               // A limit hit coinciding with last or a drop is an ordinary release.
               timeout_nxt    = ~rel_done & ~rel_drop;
               rr_ptr_nxt     = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
            end else if (hold_cnt != HOLD_LIM) begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            gnt_nxt     = '0;
            gnt_vld_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         gnt        <= '0;
         gnt_id     <= '0;
         gnt_vld    <= 1'b0;
         turnaround <= 1'b0;
         timeout    <= 1'b0;
         hold_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         rr_ptr     <= rr_ptr_nxt;
         gnt        <= gnt_nxt;
         gnt_id     <= gnt_id_nxt;
         gnt_vld    <= gnt_vld_nxt;
         turnaround <= turnaround_nxt;
         timeout    <= timeout_nxt;
         hold_cnt   <= hold_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_shared_if_arbiter.sv
// Directed bench for shared_if_arbiter: stimulus queues time-stamped expected
// outputs, a monitor pops one whenever the arbiter shows grant/turnaround/timeout.
module tb_shared_if_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic       last = 1'b0;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_vld;
   logic       turnaround;
   logic       timeout;
   logic [4:0] hold_cnt;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       vld;
      logic       ta;
      logic       to;
      logic [4:0] hc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   cyc_n    = 0;
   int   base     = 0;

   shared_if_arbiter #(
      .N_REQ    (4),
      .HOLD_MAX (16),
      .ID_W     (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .last       (last),
      .gnt        (gnt),
      .gnt_id     (gnt_id),
      .gnt_vld    (gnt_vld),
      .turnaround (turnaround),
      .timeout    (timeout),
      .hold_cnt   (hold_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic push_gnt(input int t, input int owner, input int hc);
      exp_t e;
      e.cyc = base + t;
      e.gnt = 4'b0001 << owner;
      e.id  = 2'(owner);
      e.vld = 1'b1;
      e.ta  = 1'b0;
      e.to  = 1'b0;
      e.hc  = 5'(hc);
      sb.push_back(e);
   endtask

   task automatic push_rel(input int t, input logic to);
      exp_t e;
      e.cyc = base + t;
      e.gnt = '0;
      e.id  = '0;
      e.vld = 1'b0;
      e.ta  = 1'b1;
      e.to  = to;
      e.hc  = '0;
      sb.push_back(e);
   endtask

   task automatic step(input logic [3:0] r, input logic l);
      req  = r;
      last = l;
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, want);
      end
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               checks++;
               if (!$onehot0(gnt) || (gnt_vld != |gnt) || (turnaround && gnt_vld)) begin
                  failures++;
                  $display("FAIL invariant cyc=%0d gnt=%b vld=%b ta=%b", cyc_n, gnt, gnt_vld, turnaround);
               end
               if (gnt_vld || turnaround || timeout) begin
                  checks++;
                  if (sb.size() == 0) begin
                     failures++;
                     $display("FAIL unexpected_output cyc=%0d gnt=%b ta=%b to=%b", cyc_n, gnt, turnaround, timeout);
                  end else begin
                     mon_e = sb.pop_front();
                     if (mon_e.cyc != cyc_n || gnt !== mon_e.gnt || gnt_vld !== mon_e.vld ||
                         turnaround !== mon_e.ta || timeout !== mon_e.to || hold_cnt !== mon_e.hc ||
                         (mon_e.vld && gnt_id !== mon_e.id)) begin
                        failures++;
                        $display("FAIL sb_output actual cyc=%0d gnt=%b id=%0d vld=%b ta=%b to=%b hc=%0d required cyc=%0d gnt=%b id=%0d vld=%b ta=%b to=%b hc=%0d",
                                 cyc_n, gnt, gnt_id, gnt_vld, turnaround, timeout, hold_cnt,
                                 mon_e.cyc, mon_e.gnt, mon_e.id, mon_e.vld, mon_e.ta, mon_e.to, mon_e.hc);
                     end
                  end
               end
            end
         end
      join_none

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_gnt_id", 32'(gnt_id), 0);
      chk("rst_gnt_vld", 32'(gnt_vld), 0);
      chk("rst_turnaround", 32'(turnaround), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_hold_cnt", 32'(hold_cnt), 0);
      rst = 1'b0;
      step(4'b0000, 1'b0);

      // Single requester, then rr_ptr=3 shown by picking 3 out of 1111
      base = cyc_n;
      push_gnt(1, 2, 1); push_gnt(2, 2, 2); push_gnt(3, 2, 3); push_rel(4, 1'b0);
      push_gnt(7, 3, 1); push_rel(8, 1'b0);
      step(4'b0100, 1'b0); step(4'b0100, 1'b0); step(4'b0100, 1'b0); step(4'b0100, 1'b1);
      step(4'b0000, 1'b0); step(4'b0000, 1'b0); step(4'b1111, 1'b0); step(4'b0000, 1'b1);
      step(4'b0000, 1'b0); step(4'b0000, 1'b0);

      // Round robin 0,1,2,3,0 with last on the second grant cycle
      base = cyc_n;
      for (int k = 0; k < 5; k++) begin
         push_gnt(1 + 3*k, k % 4, 1);
         push_gnt(2 + 3*k, k % 4, 2);
         push_rel(3 + 3*k, 1'b0);
      end
      for (int t = 0; t < 17; t++) step((t < 14) ? 4'b1111 : 4'b0000, (t % 3) == 2);

      // Hold limit: forced release with timeout, then re-grant to 0
      base = cyc_n;
      for (int h = 1; h <= 16; h++) push_gnt(h, 0, h);
      push_rel(17, 1'b1);
      push_gnt(18, 0, 1);
      push_rel(19, 1'b0);
      for (int t = 0; t < 21; t++) step((t < 18) ? 4'b0001 : 4'b0000, 1'b0);

      // last exactly at the hold limit: no timeout
      base = cyc_n;
      for (int h = 1; h <= 16; h++) push_gnt(h, 1, h);
      push_rel(17, 1'b0);
      for (int t = 0; t < 19; t++) step((t < 17) ? 4'b0010 : 4'b0000, t == 16);

      // Async reset mid-grant (rr_ptr=2 beforehand); afterwards 0 wins
      base = cyc_n;
      push_gnt(1, 1, 1); push_gnt(2, 1, 2); push_gnt(3, 0, 1); push_rel(4, 1'b0);
      step(4'b0010, 1'b0); step(4'b0010, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk("async_gnt", 32'(gnt), 0);
      chk("async_gnt_vld", 32'(gnt_vld), 0);
      chk("async_hold_cnt", 32'(hold_cnt), 0);
      chk("async_turnaround", 32'(turnaround), 0);
      req = 4'b1111;
      #1 rst = 1'b0;
      @(negedge clk);
      step(4'b0000, 1'b0); step(4'b0000, 1'b0); step(4'b0000, 1'b0);

      // Owner 1 drops its request while 3 waits
      base = cyc_n;
      for (int h = 1; h <= 5; h++) push_gnt(h, 1, h);
      push_rel(6, 1'b0);
      push_gnt(7, 3, 1); push_gnt(8, 3, 2); push_rel(9, 1'b0);
      step(4'b0010, 1'b0);
      for (int t = 1; t < 5; t++) step(4'b1010, 1'b0);
      step(4'b1000, 1'b0); step(4'b1000, 1'b0); step(4'b1000, 1'b0);
      step(4'b0000, 1'b1); step(4'b0000, 1'b0); step(4'b0000, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
